icache_dm: RTL
==============

Name: icache_dm

Overview:
- Parametrised direct-mapped instruction cache; next generation of the per-core instruction ROM in the dual-core processor.
- Sits between the fetch stage and a shared, slower backing instruction memory.
- Hits return the instruction combinationally, in the same cycle, exactly as the ROM does.
- Misses stall fetch while a refill FSM loads a full line over a req/valid handshake.

Parameters:
- ADDR_W, 32, fetch/memory byte-address width.
- DATA_W, 32, instruction word width.
- LINES, 16, number of cache lines (power of 2, >=2).
- WORDS_PER_LINE, 4, words per line (power of 2, >=2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- A  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- fetch_req  in  1  fetch valid this cycle.
- RD  out  DATA_W  instruction; valid when ready=1.
- ready  out  1  hit this cycle (combinational).
- stall  out  1  fetch_req=1 and ready=0; fetch holds A.
- flush  in  1  invalidate all lines.
- mem_req  out  1  backing-memory word request.
- mem_addr  out  ADDR_W  word-aligned request address.
- mem_rdata  in  DATA_W  returned word.
- mem_valid  in  1  mem_rdata valid; one word per pulse.

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE) bits at [OFF+1:2].
  - IDX = log2(LINES) bits above OFF.
  - TAG = remaining upper bits.
- Storage: data array LINES*WORDS_PER_LINE x DATA_W; tag array LINES x TAG bits; valid bit per line.
- Hit: fetch_req & valid[idx] & tag[idx]==A.tag & state==IDLE.
  - ready=1, RD=data[idx][off], zero latency.
- ready=0 whenever state!=IDLE.
- RD is don't-care when ready=0; the bench checks RD only when ready=1.
- FSM states: IDLE, REFILL, COMMIT.
  - IDLE -> REFILL: on fetch_req & miss. Latch line base (A with OFF and [1:0] zeroed) and index; clear word counter.
  - REFILL:
    - mem_req=1; mem_addr = base + 4*cnt.
    - On mem_valid: write mem_rdata to data[idx][cnt]; cnt++.
    - After the last word (cnt==WORDS_PER_LINE-1 with mem_valid) -> COMMIT.
    - mem_req stays high with the new address the cycle after each mem_valid. Address is stable while waiting.
  - COMMIT: write tag, set valid[idx], mem_req=0 -> IDLE. The same fetch then hits in the following cycle.
- Minimum miss penalty: WORDS_PER_LINE + 2 cycles (mem_valid every cycle).
- mem_valid outside REFILL is ignored.
- Fetch address changing during REFILL is ignored; the latched line still completes.
- Flush:
  - In IDLE: clears all valid bits at the edge. ready is still evaluated against pre-flush state that cycle.
  - Flush during REFILL or COMMIT sets flush_pending. The refill completes, but COMMIT does not set valid. All valid bits are cleared on entry to IDLE.
  - flush and fetch_req miss in the same IDLE cycle: both act (clear all, start refill).
- Reset (any state, including mid-refill):
  - state=IDLE, all valid=0, cnt=0, flush_pending=0.
  - mem_req=0, mem_addr=0, ready=0, stall=fetch_req.
  - Data and tag arrays are not cleared.
  - A partially refilled line is never valid.
- Wrap-around: the counter covers exactly WORDS_PER_LINE words; the address never crosses the line boundary.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined: adds output ports hit_count and miss_count, 32 bits each.
  - hit_count increments on each cycle with ready=1.
  - miss_count increments on each IDLE->REFILL transition.
  - Both saturate at 0xFFFFFFFF and clear on reset (not on flush).
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, fetch A=0x00, memory returns word=addr^0xA5A5A5A5 every cycle -> mem_addr 0x00,0x04,0x08,0x0C; stall 6 cycles; then ready=1, RD=0xA5A5A5A5.
- After that refill, fetch 0x04, 0x08, 0x0C in consecutive cycles -> ready=1 every cycle, RD=0xA5A5A5A1/..AD/..A9, mem_req=0.
- Fetch 0x100 (defaults: index 0, new tag) -> miss, refill 0x100-0x10C; then 0x00 -> miss again (conflict eviction).
- mem_valid delayed 3 cycles per word -> mem_addr held stable while waiting, words stored in order; miss penalty 4*4+2=18 cycles.
- Assert reset on the 2nd mem_valid of a refill -> mem_req=0 next cycle; refetching the same address misses and refills all 4 words.
- Flush during REFILL of 0x40 -> refill completes; next fetch of 0x40 misses. With ICACHE_STATS_EN: miss_count=2, hit_count matches counted ready cycles.

Source files
------------

// File: rtl/icache_dm.sv
// -----------------------------------------------------------------------------
// icache_dm -- parametrised direct-mapped instruction cache.
//
// Sits between the fetch stage and a shared, slower backing instruction memory.
// A hit returns the instruction combinationally in the same cycle. A miss
// stalls fetch while a refill FSM (IDLE -> REFILL -> COMMIT) loads a whole line
// over a req/valid handshake.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high reset
//   A          fetch byte address (bits [1:0] ignored)
//   fetch_req  fetch valid this cycle
//   RD         instruction, valid when ready=1
//   ready      hit this cycle (combinational)
//   stall      fetch_req=1 and ready=0; fetch holds A
//   flush      invalidate all lines
//   mem_req    backing-memory word request
//   mem_addr   word-aligned request address (0 when mem_req=0)
//   mem_rdata  returned word
//   mem_valid  mem_rdata valid; one word per pulse
//   hit_count  (ICACHE_STATS_EN only) saturating count of ready cycles
//   miss_count (ICACHE_STATS_EN only) saturating count of refills started
//
// Optional build macro: ICACHE_STATS_EN adds the hit/miss statistics counters.
// -----------------------------------------------------------------------------
module icache_dm #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] A,
    input  logic              fetch_req,
    output logic [DATA_W-1:0] RD,
    output logic              ready,
    output logic              stall,
    input  logic              flush,
`ifdef ICACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    // Fetch address fields
    logic [OFF_W-1:0] a_off;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;
    logic [1:0]       unused_a_lsbs;

    assign a_off         = A[OFF_W+1:2];
    assign a_idx         = A[IDX_W+OFF_W+1:OFF_W+2];
    assign a_tag         = A[ADDR_W-1:ADDR_W-TAG_W];
    assign unused_a_lsbs = A[1:0];

    // Storage
    logic [DATA_W-1:0] data_mem [LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid;

    // Refill FSM state
    logic [1:0]        state;
    logic [OFF_W-1:0]  cnt;
    logic [ADDR_W-1:0] line_base;
    logic [IDX_W-1:0]  refill_idx;
    logic              flush_pending;

    logic hit;
    logic start_refill;

    assign hit = fetch_req && (state == S_IDLE) && valid[a_idx] && (tag_mem[a_idx] == a_tag);
    assign start_refill = fetch_req && (state == S_IDLE) && !hit;

    assign ready = hit;
    assign RD    = data_mem[{a_idx, a_off}];
    assign stall = fetch_req && !hit;

    assign mem_req  = (state == S_REFILL);
    // Line base has OFF and byte bits zero, so adding 4*cnt never leaves the line.
    assign mem_addr = mem_req ? (line_base + {{(ADDR_W-OFF_W-2){1'b0}}, cnt, 2'b00}) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            valid         <= '0;
            cnt           <= '0;
            line_base     <= '0;
            refill_idx    <= '0;
            flush_pending <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // ready was already judged against the pre-flush valid bits.
                    if (flush) valid <= '0;
                    if (start_refill) begin
                        state      <= S_REFILL;
                        line_base  <= {A[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
                        refill_idx <= a_idx;
                        cnt        <= '0;
                    end
                end
                S_REFILL: begin
                    if (flush) flush_pending <= 1'b1;
                    if (mem_valid) begin
                        cnt <= cnt + OFF_W'(1);
                        if (cnt == LAST_WORD) state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                    // A flush seen during the refill wins over validating the line.
                    if (flush || flush_pending) begin
                        valid         <= '0;
                        flush_pending <= 1'b0;
                    end else begin
                        valid[refill_idx] <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the data and tag arrays have no reset; the valid bits alone decide
    // whether a line is usable, so the arrays can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!reset && state == S_REFILL && mem_valid)
            data_mem[{refill_idx, cnt}] <= mem_rdata;
        if (!reset && state == S_COMMIT)
            tag_mem[refill_idx] <= line_base[ADDR_W-1:ADDR_W-TAG_W];
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ready && hit_count != '1)         hit_count  <= hit_count + 32'd1;
            if (start_refill && miss_count != '1) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
